// File: rtl/bus_to_sample.sv
// bus_to_sample: unpacks 64-bit words into eight sample lines, one byte per
// sample tick, byte 0 first. Owns a free-running sample-rate divider, a
// one-word holding buffer and an active shift source so a second word can be
// queued while the first is still being played out.
module bus_to_sample #(
  parameter int DIV = 5000
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic [63:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        bit0,
  output logic        bit1,
  output logic        bit2,
  output logic        bit3,
  output logic        bit4,
  output logic        bit5,
  output logic        bit6,
  output logic        bit7,
  output logic        sample_strobe,
  output logic        busy,
  output logic        underrun
);

  // A 1-bit counter is the minimum even for the smallest divider.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  logic [63:0]   buf_q, buf_d;
  logic          buf_full_q, buf_full_d;
  logic [63:0]   act_q, act_d;
  logic [2:0]    idx_q, idx_d;

  logic [7:0]    bits_q, bits_d;
  logic          strobe_q, strobe_d;
  logic          under_q, under_d;
  logic          streaming_q, streaming_d;

  logic          accept;

  // The tick phase is independent of data: the counter only restarts on rst.
  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Divider register.
  always_ff @(posedge clk_50mhz) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Holding buffer accepts only when empty; a drain cycle therefore never
  // coincides with an accept, the new word lands one cycle later.
  assign in_ready = !buf_full_q && !rst;
  assign accept   = in_valid && in_ready;

  // Next-state: buffer fill, active load, byte playout and underrun detect.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    act_d       = act_q;
    idx_d       = idx_q;
    bits_d      = bits_q;
    strobe_d    = 1'b0;
    under_d     = 1'b0;
    streaming_d = streaming_q;

    if (accept) begin
      buf_d      = in_word;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // A tick here means the line went without fresh data; report once
        // per gap. A tick in the load cycle is not used for playout.
        if (tick && streaming_q) begin
          under_d     = 1'b1;
          streaming_d = 1'b0;
        end
        if (buf_full_q) begin
          act_d      = buf_q;
          buf_full_d = 1'b0;
          idx_d      = 3'd0;
          state_d    = SEND;
        end
      end

      SEND: begin
        if (tick) begin
          bits_d      = act_q[{idx_q, 3'b000} +: 8];
          strobe_d    = 1'b1;
          streaming_d = 1'b1;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            // Chain straight into the buffered word so its byte 0 lands on
            // the very next tick; otherwise drop back to idle.
            if (buf_full_q) begin
              act_d      = buf_q;
              buf_full_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; rst discards active and buffered data.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      act_q       <= '0;
      idx_q       <= 3'd0;
      bits_q      <= '0;
      strobe_q    <= 1'b0;
      under_q     <= 1'b0;
      streaming_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      act_q       <= act_d;
      idx_q       <= idx_d;
      bits_q      <= bits_d;
      strobe_q    <= strobe_d;
      under_q     <= under_d;
      streaming_q <= streaming_d;
    end
  end

  assign bit0          = bits_q[0];
  assign bit1          = bits_q[1];
  assign bit2          = bits_q[2];
  assign bit3          = bits_q[3];
  assign bit4          = bits_q[4];
  assign bit5          = bits_q[5];
  assign bit6          = bits_q[6];
  assign bit7          = bits_q[7];
  assign sample_strobe = strobe_q;
  assign underrun      = under_q;
  assign busy          = (state_q == SEND);

endmodule

// File: tb/tb_bus_to_sample.sv
// Bench for bus_to_sample: three instances (DIV 4, 2, 7) checked every cycle
// against a word/byte-level model, plus literal byte-sequence and spacing
// checks on the strobe log.
module tb_bus_to_sample;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int divs [3] = '{4, 2, 7};

  logic [2:0]        rst_v;
  logic [2:0]        vld;
  logic [2:0][63:0]  word;
  wire  [2:0]        rdy, stb, bsy, und;
  wire  [2:0][7:0]   bv;

  bus_to_sample #(.DIV(4)) u_d4 (
    .clk_50mhz(clk), .rst(rst_v[0]), .in_word(word[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]),
    .bit0(bv[0][0]), .bit1(bv[0][1]), .bit2(bv[0][2]), .bit3(bv[0][3]),
    .bit4(bv[0][4]), .bit5(bv[0][5]), .bit6(bv[0][6]), .bit7(bv[0][7]),
    .sample_strobe(stb[0]), .busy(bsy[0]), .underrun(und[0]));

  bus_to_sample #(.DIV(2)) u_d2 (
    .clk_50mhz(clk), .rst(rst_v[1]), .in_word(word[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]),
    .bit0(bv[1][0]), .bit1(bv[1][1]), .bit2(bv[1][2]), .bit3(bv[1][3]),
    .bit4(bv[1][4]), .bit5(bv[1][5]), .bit6(bv[1][6]), .bit7(bv[1][7]),
    .sample_strobe(stb[1]), .busy(bsy[1]), .underrun(und[1]));

  bus_to_sample #(.DIV(7)) u_d7 (
    .clk_50mhz(clk), .rst(rst_v[2]), .in_word(word[2]), .in_valid(vld[2]),
    .in_ready(rdy[2]),
    .bit0(bv[2][0]), .bit1(bv[2][1]), .bit2(bv[2][2]), .bit3(bv[2][3]),
    .bit4(bv[2][4]), .bit5(bv[2][5]), .bit6(bv[2][6]), .bit7(bv[2][7]),
    .sample_strobe(stb[2]), .busy(bsy[2]), .underrun(und[2]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a pending word slot, the word being played with bytes left, and
  // a tick that fires every DIV-th cycle counted from reset release.
  int          m_cnt  [3];
  logic [63:0] m_pend [3];
  bit          m_pfull[3];
  logic [63:0] m_cur  [3];
  int          m_left [3];
  logic [7:0]  m_bits [3];
  bit          m_stb  [3];
  bit          m_und  [3];
  bit          m_strm [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_pfull[i] = 0; m_left[i] = 0; m_bits[i] = 0;
      m_stb[i] = 0; m_und[i] = 0; m_strm[i] = 0; m_pend[i] = 0; m_cur[i] = 0;
    end
  end

  always @(posedge clk) begin
    bit acc, tk;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst_v[i]) begin
        m_cnt[i] = 0; m_pfull[i] = 0; m_left[i] = 0; m_bits[i] = 0;
        m_stb[i] = 0; m_und[i] = 0; m_strm[i] = 0;
      end else begin
        acc = vld[i] && !m_pfull[i];
        tk  = (m_cnt[i] == divs[i] - 1);
        m_cnt[i] = tk ? 0 : m_cnt[i] + 1;
        m_stb[i] = 0;
        m_und[i] = 0;
        if (m_left[i] == 0) begin
          if (tk && m_strm[i]) begin m_und[i] = 1; m_strm[i] = 0; end
          if (m_pfull[i]) begin
            m_cur[i] = m_pend[i]; m_left[i] = 8; m_pfull[i] = 0;
          end
        end else if (tk) begin
          m_bits[i] = m_cur[i][8*(8-m_left[i]) +: 8];
          m_stb[i]  = 1;
          m_strm[i] = 1;
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0 && m_pfull[i]) begin
            m_cur[i] = m_pend[i]; m_left[i] = 8; m_pfull[i] = 0;
          end
        end
        if (acc) begin m_pend[i] = word[i]; m_pfull[i] = 1; end
      end
    end
  end

  // Strobe/underrun log for the literal checks.
  logic [7:0] lb [3][64];
  int         lc [3][64];
  int         ln [3];
  int         nund [3];

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("outs%0d", i),
          {52'd0, bv[i], stb[i], bsy[i], und[i], rdy[i]},
          {52'd0, m_bits[i], m_stb[i], (m_left[i] != 0), m_und[i], (!m_pfull[i] && !rst_v[i])});
      if (stb[i] && ln[i] < 64) begin
        lb[i][ln[i]] = bv[i];
        lc[i][ln[i]] = cyc;
        ln[i]++;
      end
      if (und[i]) nund[i]++;
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic tick_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_log(input int i);
    ln[i] = 0;
    nund[i] = 0;
  endtask

  task automatic send(input int i, input logic [63:0] w);
    bit a;
    bit done;
    done = 0;
    vld[i] = 1'b1;
    word[i] = w;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(negedge clk);
      a = rdy[i];
      @(posedge clk);
      #1;
      if (a) done = 1;
    end
    vld[i] = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  // Literal check of 8 logged bytes of w starting at log entry base.
  task automatic chk_word(input int i, input logic [63:0] w, input int base);
    for (int k = 0; k < 8; k++) begin
      if (base + k < ln[i]) begin
        chk($sformatf("byte%0d_%0d", i, base + k), {56'd0, lb[i][base+k]}, {56'd0, w[8*k +: 8]});
        if (base + k > 0)
          chk($sformatf("space%0d_%0d", i, base + k),
              64'(lc[i][base+k] - lc[i][base+k-1]), 64'(divs[i]));
      end
    end
  endtask

  initial begin
    rst_v = 3'b111;
    vld   = 3'b111;
    for (int i = 0; i < 3; i++) begin
      word[i] = 64'hDEAD_BEEF_0000_0001;
      ln[i] = 0;
      nund[i] = 0;
    end

    // Reset held 3 cycles with in_valid high: nothing accepted.
    tick_wait(3);
    chk("rst_ready", {63'd0, rdy[0]}, 64'd0);
    chk("rst_bits", {56'd0, bv[0]}, 64'd0);
    rst_v = 3'b000;
    vld   = 3'b000;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, rdy[0]}, 64'd1);
    chk("post_rst_busy", {63'd0, bsy[0]}, 64'd0);
    @(posedge clk); #1;

    // Single word, DIV=4.
    clr_log(0);
    send(0, 64'h0807060504030201);
    tick_wait(50);
    chk("single_n", 64'(ln[0]), 64'd8);
    chk_word(0, 64'h0807060504030201, 0);
    chk("single_last", {56'd0, lb[0][7]}, 64'h08);
    chk("single_hold", {56'd0, bv[0]}, 64'h08);
    chk("single_busy", {63'd0, bsy[0]}, 64'd0);
    chk("single_under", 64'(nund[0]), 64'd1);

    // Back-to-back plus a third word held under backpressure.
    clr_log(0);
    send(0, {8{8'h11}});
    send(0, {8{8'h22}});
    send(0, {8{8'hAA}});
    tick_wait(110);
    chk("b2b_n", 64'(ln[0]), 64'd24);
    chk_word(0, {8{8'h11}}, 0);
    chk_word(0, {8{8'h22}}, 8);
    chk_word(0, {8{8'hAA}}, 16);
    chk("b2b_under", 64'(nund[0]), 64'd1);

    // Reset after the 3rd strobe; next word restarts at byte 0.
    clr_log(0);
    send(0, 64'h0807060504030201);
    for (int n = 0; n < 200 && ln[0] < 3; n++) tick_wait(1);
    chk("mid_n", 64'(ln[0]), 64'd3);
    rst_v[0] = 1'b1;
    tick_wait(1);
    chk("mid_rst_bits", {56'd0, bv[0]}, 64'd0);
    chk("mid_rst_busy", {63'd0, bsy[0]}, 64'd0);
    rst_v[0] = 1'b0;
    tick_wait(1);
    clr_log(0);
    send(0, 64'hFFEEDDCCBBAA9988);
    tick_wait(50);
    chk("mid_next_n", 64'(ln[0]), 64'd8);
    chk("mid_first", {56'd0, lb[0][0]}, 64'h88);
    chk_word(0, 64'hFFEEDDCCBBAA9988, 0);

    // Divider spacing at DIV=2 and DIV=7.
    clr_log(1);
    send(1, 64'h0807060504030201);
    tick_wait(30);
    chk("div2_n", 64'(ln[1]), 64'd8);
    chk_word(1, 64'h0807060504030201, 0);
    chk("div2_gap", 64'(lc[1][7] - lc[1][0]), 64'd14);

    clr_log(2);
    send(2, 64'h0807060504030201);
    tick_wait(80);
    chk("div7_n", 64'(ln[2]), 64'd8);
    chk_word(2, 64'h0807060504030201, 0);
    chk("div7_gap", 64'(lc[2][7] - lc[2][0]), 64'd49);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_to_sample.md
# bus_to_sample

Serialiser that unpacks 64-bit sample words into eight 1-bit output lines, one byte per sample tick. It is the playback counterpart of the sample-to-bus packer: byte 0 (`in_word[7:0]`) is driven first and byte 7 (`in_word[63:56]`) last, so a packer → bus → `bus_to_sample` loop reproduces the original bit streams in order. It sits between a word source (FIFO or CPU register) and the eight physical sample lines, and owns its own sample-rate divider from the 50 MHz FPGA clock.

## Interface
- `DIV`, 5000: sample-tick period in `clk_50mhz` cycles (5000 → 10 kHz); legal range 2..65535.
- `clk_50mhz` input 1: 50 MHz FPGA clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_word` input 64: word to serialise; byte k = `in_word[8k+7:8k]`.
- `in_valid` input 1: `in_word` is valid.
- `in_ready` output 1: block accepts a word this cycle; transfer when `in_valid && in_ready`.
- `bit0`..`bit7` output 1 each: current sample; `bitN` = bit N of the current byte.
- `sample_strobe` output 1: one-cycle pulse in the cycle a new byte first appears on `bit0..bit7`.
- `busy` output 1: a word is being serialised (active register loaded).
- `underrun` output 1: one-cycle pulse on a tick with no data while streaming.

## Operation
- Tick generator: free-running counter 0..`DIV`-1; `tick` is asserted for one cycle when the counter is at `DIV`-1, then the counter wraps to 0. The counter is never restarted by data arrival; it is reset only by `rst`. Its width is clog2(`DIV`).
- Storage: one 64-bit holding buffer (`buf_full`) and one 64-bit active register with a 3-bit byte index `idx`.
- `in_ready = !buf_full && !rst`. An accepted word goes into the holding buffer at the next edge.
- State machine:
  - IDLE: `busy`=0. If `buf_full`, move the buffer to the active register on the next edge, clear `buf_full`, set `idx`=0, and go to SEND.
  - SEND: `busy`=1. On `tick`, drive byte `idx` on `bit0..bit7`, pulse `sample_strobe`, and increment `idx`.
    - After driving byte 7 (`idx` wraps 7→0): if `buf_full` in the same cycle, load the buffer into the active register and clear `buf_full`. SEND continues, so the next tick drives the new byte 0 with no gap.
    - If the buffer is empty, go to IDLE.
- Outputs hold the last driven byte between ticks and while IDLE.
- Underrun: a flag `streaming` is set when the first byte of any word is driven and cleared by `rst`. A `tick` in IDLE with `streaming`=1 pulses `underrun` and clears `streaming`, so there is one pulse per gap.
- Simultaneous events:
  - Buffer drain and `in_valid` in the same cycle: no accept that cycle, because `in_ready` is still 0. Acceptance happens the following cycle.
  - Acceptance and `tick` in the same cycle while IDLE: the tick is not used. The word waits for the next tick.

## Timing
- Reset values: `bit0..bit7`=0, `sample_strobe`=0, `busy`=0, `underrun`=0, `in_ready`=0 while `rst`=1, tick counter=0, `idx`=0, `buf_full`=0, `streaming`=0. The state machine is in IDLE.
- `in_ready`=1 in the first cycle after `rst` deasserts.
- Accept at edge E → `buf_full` at E+1 → active loaded and `busy`=1 at E+2 → first byte on the first tick edge after E+2.
- Byte-to-byte spacing is exactly `DIV` cycles. A 64-bit word occupies 8 ticks.
- Back-to-back words produce 16 strobes at uniform `DIV` spacing, provided word 2 is accepted before byte 7 of word 1 is driven.
- `rst` mid-word: active and buffered data are discarded on the reset edge. The next accepted word starts at byte 0.

## Test plan
- Reset: hold `rst` for 3 cycles with `in_valid`=1 → all outputs 0, no acceptance. The cycle after release, `in_ready`=1 and `busy`=0.
- Single word, `DIV`=4, `in_word`=64'h0807060504030201 → 8 strobes exactly 4 cycles apart carrying bytes 01,02,…,08. Afterwards `busy`=0, bits hold 8'h08, and `underrun` pulses once on the next tick only.
- Back-to-back, `DIV`=4, words 64'h1111…11 then 64'h2222…22, the second offered immediately → 16 strobes with uniform 4-cycle spacing (8×11 then 8×22). `in_ready` is 0 while the buffer is full. `underrun` does not pulse until after the last byte.
- Backpressure: active and buffer full, `in_valid`=1 with 64'hAAAA…AA held → not accepted until the buffer drains. The word is later emitted intact, exactly once.
- Reset mid-word, `DIV`=4: assert `rst` after the 3rd strobe of 64'h0807060504030201 → bits=0 and `busy`=0. The next word 64'hFFEEDDCCBBAA9988 emits 88 first.
- Divider: `DIV`=2 and `DIV`=7 → strobe spacing is exactly 2 and 7 cycles respectively, over a full word.
